otp_auth_fsm_param: RTL and testbench

- Parametrised successor to the single-configuration OTP authentication FSM.
- Captures a generated OTP, collects user digits (with delete), compares them, and drives unlock, expiry and lockout status.
- Configurable: digit count, digit width, attempt limit, and all timeouts.
- Adds explicit session start, digit delete, dedicated expired/lockout states and a state-visible debug output. Sits between the LFSR OTP generator and the keypad/display logic.

---
 rtl/otp_auth_fsm_param.sv | 139 +++++++++++++
 tb/tb_otp_auth_fsm_param.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/otp_auth_fsm_param.sv
// otp_auth_fsm_param: captures a generated OTP, collects keypad digits with delete, compares them and drives unlock/expiry/lockout status
// Ports: clk, reset (sync, active-low); start opens a session from IDLE; otp_in/otp_valid deliver the generated OTP;
// user_digit/user_latch/user_del edit the entry buffer; otp and user_otp_out expose captured OTP and entry (digit 0 in MS bits);
// digit_cnt, wrng_atmpt, unlock, expired, locked report progress; state exposes the FSM encoding.
module otp_auth_fsm_param #(
  parameter int N_DIGITS       = 4,
  parameter int DIGIT_W        = 4,
  parameter int MAX_ATTEMPTS   = 3,
  parameter int EXPIRE_CYCLES  = 2500,
  parameter int HOLD_CYCLES    = 250,
  parameter int LOCKOUT_CYCLES = 1000
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  input  logic [N_DIGITS*DIGIT_W-1:0]          otp_in,
  input  logic                                 otp_valid,
  input  logic [DIGIT_W-1:0]                   user_digit,
  input  logic                                 user_latch,
  input  logic                                 user_del,
  output logic [N_DIGITS*DIGIT_W-1:0]          otp,
  output logic [N_DIGITS*DIGIT_W-1:0]          user_otp_out,
  output logic [$clog2(N_DIGITS+1)-1:0]        digit_cnt,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0]    wrng_atmpt,
  output logic                                 unlock,
  output logic                                 expired,
  output logic                                 locked,
  output logic [2:0]                           state
);
  localparam int OW = N_DIGITS*DIGIT_W;
  localparam int CW = $clog2(N_DIGITS+1);
  localparam int AW = $clog2(MAX_ATTEMPTS+1);
  localparam int TW = $clog2(EXPIRE_CYCLES+1);
  localparam int HM = HOLD_CYCLES > LOCKOUT_CYCLES ? HOLD_CYCLES : LOCKOUT_CYCLES;
  localparam int HW = $clog2(HM+1);
  typedef enum logic [2:0] {IDLE, WAIT_OTP, ENTER, CHECK, UNLOCK, EXPIRED, LOCKOUT} state_t;
  state_t st, st_n;
  logic [OW-1:0] otp_n, buf_n;
  logic [CW-1:0] cnt_n;
  logic [AW-1:0] wrng_n;
  logic [TW-1:0] timer, timer_n;
  logic [HW-1:0] hold, hold_n;
  logic unlock_n, expired_n, locked_n;
  assign state = st;
  always_ff @(posedge clk) begin
    if (!reset) begin
      st <= IDLE;
      otp <= '0;
      user_otp_out <= '0;
      digit_cnt <= '0;
      wrng_atmpt <= '0;
      unlock <= 1'b0;
      expired <= 1'b0;
      locked <= 1'b0;
      timer <= '0;
      hold <= '0;
    end else begin
      st <= st_n;
      otp <= otp_n;
      user_otp_out <= buf_n;
      digit_cnt <= cnt_n;
      wrng_atmpt <= wrng_n;
      unlock <= unlock_n;
      expired <= expired_n;
      locked <= locked_n;
      timer <= timer_n;
      hold <= hold_n;
    end
  end
  always_comb begin
    st_n = st;
    otp_n = otp;
    buf_n = user_otp_out;
    cnt_n = digit_cnt;
    wrng_n = wrng_atmpt;
    unlock_n = unlock;
    expired_n = expired;
    locked_n = locked;
    timer_n = timer;
    hold_n = hold;
    case (st)
      IDLE: if (start) st_n = WAIT_OTP;
      WAIT_OTP: if (otp_valid) begin
        otp_n = otp_in;
        timer_n = '0;
        st_n = ENTER;
      end
      ENTER: begin
        timer_n = timer + 1'b1;
        // expiry wins over any same-cycle keypad strobe
        if (timer == TW'(EXPIRE_CYCLES-1)) begin
          st_n = EXPIRED;
          expired_n = 1'b1;
          hold_n = '0;
        end else if (user_latch) begin
          for (int i = 0; i < N_DIGITS; i++)
            if (i == int'(digit_cnt)) buf_n[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = user_digit;
          cnt_n = digit_cnt + 1'b1;
          if (digit_cnt == CW'(N_DIGITS-1)) st_n = CHECK;
        end else if (user_del && digit_cnt != '0) begin
          for (int i = 0; i < N_DIGITS; i++)
            if (i == int'(digit_cnt) - 1) buf_n[(N_DIGITS-1-i)*DIGIT_W +: DIGIT_W] = '0;
          cnt_n = digit_cnt - 1'b1;
        end
      end
      CHECK: if (otp == user_otp_out) begin
        st_n = UNLOCK;
        unlock_n = 1'b1;
        hold_n = '0;
      end else begin
        wrng_n = wrng_atmpt + 1'b1;
        if (wrng_atmpt == AW'(MAX_ATTEMPTS-1)) begin
          st_n = LOCKOUT;
          locked_n = 1'b1;
          hold_n = '0;
        end else begin
          st_n = ENTER;
          buf_n = '0;
          cnt_n = '0;
        end
      end
      UNLOCK, EXPIRED: if (hold == HW'(HOLD_CYCLES-1)) st_n = IDLE; else hold_n = hold + 1'b1;
      LOCKOUT: if (hold == HW'(LOCKOUT_CYCLES-1)) st_n = IDLE; else hold_n = hold + 1'b1;
      default: st_n = IDLE;
    endcase
    // everything reads zero whenever the FSM sits in IDLE, including on the entering edge
    if (st_n == IDLE) begin
      otp_n = '0;
      buf_n = '0;
      cnt_n = '0;
      wrng_n = '0;
      unlock_n = 1'b0;
      expired_n = 1'b0;
      locked_n = 1'b0;
      timer_n = '0;
      hold_n = '0;
    end
  end
endmodule

// File: tb/tb_otp_auth_fsm_param.sv
// tb_otp_auth_fsm_param: directed scenarios plus randomized sessions checked every cycle against a queue-based model
module tb_otp_auth_fsm_param;
  localparam int EXP = 200, HOLD = 10, LOCK = 30, MAXA = 3;
  logic clk = 0, reset = 0, start = 0, otp_valid = 0, user_latch = 0, user_del = 0;
  logic [15:0] otp_in = '0, otp, user_otp_out;
  logic [3:0] user_digit = '0;
  logic [2:0] digit_cnt, state;
  logic [1:0] wrng_atmpt;
  logic unlock, expired, locked;
  int n_cmp = 0, n_bad = 0, mode = 0;
  int m_state = 0, m_wrong = 0, m_elapsed = 0, m_left = 0;
  logic [15:0] m_otp = '0;
  logic [3:0] dq[$];
  bit m_unlock = 0, m_exp = 0, m_lock = 0;
  otp_auth_fsm_param #(.N_DIGITS(4), .DIGIT_W(4), .MAX_ATTEMPTS(MAXA), .EXPIRE_CYCLES(EXP),
    .HOLD_CYCLES(HOLD), .LOCKOUT_CYCLES(LOCK)) dut (.clk(clk), .reset(reset), .start(start),
    .otp_in(otp_in), .otp_valid(otp_valid), .user_digit(user_digit), .user_latch(user_latch),
    .user_del(user_del), .otp(otp), .user_otp_out(user_otp_out), .digit_cnt(digit_cnt),
    .wrng_atmpt(wrng_atmpt), .unlock(unlock), .expired(expired), .locked(locked), .state(state));
  always #5 clk = ~clk;
  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endfunction
  function automatic logic [15:0] pack_q();
    logic [15:0] v = '0;
    foreach (dq[i]) v[15-4*i -: 4] = dq[i];
    return v;
  endfunction
  function automatic void m_clear();
    m_state = 0; m_otp = '0; dq.delete(); m_wrong = 0; m_elapsed = 0; m_left = 0;
    m_unlock = 0; m_exp = 0; m_lock = 0;
  endfunction
  always @(posedge clk) begin
    if (!reset) m_clear();
    else case (m_state)
      0: if (start) m_state = 1;
      1: if (otp_valid) begin m_otp = otp_in; m_elapsed = 0; m_state = 2; end
      2: begin
        m_elapsed++;
        if (m_elapsed == EXP) begin m_state = 5; m_exp = 1; m_left = HOLD; end
        else if (user_latch) begin dq.push_back(user_digit); if (dq.size() == 4) m_state = 3; end
        else if (user_del && dq.size() > 0) void'(dq.pop_back());
      end
      3: if (pack_q() == m_otp) begin m_state = 4; m_unlock = 1; m_left = HOLD; end
         else begin
           m_wrong++;
           if (m_wrong == MAXA) begin m_state = 6; m_lock = 1; m_left = LOCK; end
           else begin dq.delete(); m_state = 2; end
         end
      default: begin m_left--; if (m_left <= 0) m_clear(); end
    endcase
  end
  always @(negedge clk) begin
    chk("state", 32'(state), 32'(m_state));
    chk("otp", 32'(otp), 32'(m_otp));
    chk("user_otp_out", 32'(user_otp_out), 32'(pack_q()));
    chk("digit_cnt", 32'(digit_cnt), 32'(dq.size()));
    chk("wrng_atmpt", 32'(wrng_atmpt), 32'(m_wrong));
    chk("unlock", 32'(unlock), 32'(m_unlock));
    chk("expired", 32'(expired), 32'(m_exp));
    chk("locked", 32'(locked), 32'(m_lock));
  end
  task automatic drive(input bit s, input logic [15:0] oi, input bit ov, input logic [3:0] d, input bit l, input bit dl);
    @(negedge clk);
    start = s; otp_in = oi; otp_valid = ov; user_digit = d; user_latch = l; user_del = dl;
  endtask
  task automatic idle(input int n);
    repeat (n) drive(0, 16'h0, 0, 4'h0, 0, 0);
  endtask
  task automatic lat(input logic [3:0] d);
    drive(0, 16'h0, 0, d, 1, 0);
  endtask
  task automatic enter(input logic [15:0] v);
    for (int i = 0; i < 4; i++) lat(v[15-4*i -: 4]);
  endtask
  task automatic open_session(input logic [15:0] v);
    drive(1, 16'h0, 0, 4'h0, 0, 0);
    drive(0, v, 1, 4'h0, 0, 0);
  endtask
  initial begin
    idle(2);
    chk("reset state", 32'(state), 0);
    chk("reset otp", 32'(otp), 0);
    reset = 1;
    open_session(16'h3A7C);
    enter(16'h3A7C);
    idle(1);
    chk("s1 check state", 32'(state), 3);
    chk("s1 otp", 32'(otp), 32'h3A7C);
    chk("s1 buffer", 32'(user_otp_out), 32'h3A7C);
    idle(1);
    chk("s1 unlock", 32'(unlock), 1);
    idle(9);
    chk("s1 unlock held", 32'(unlock), 1);
    idle(1);
    chk("s1 idle", 32'(state), 0);
    chk("s1 unlock off", 32'(unlock), 0);
    open_session(16'h3A7C);
    lat(4'h3); lat(4'hA); lat(4'h5);
    drive(0, 16'h0, 0, 4'h0, 0, 1);
    chk("s2 cnt3", 32'(digit_cnt), 3);
    lat(4'h7);
    chk("s2 cnt2", 32'(digit_cnt), 2);
    lat(4'hC);
    idle(1);
    chk("s2 cnt4", 32'(digit_cnt), 4);
    idle(1);
    chk("s2 unlock", 32'(unlock), 1);
    chk("s2 wrng", 32'(wrng_atmpt), 0);
    idle(10);
    open_session(16'h3A7C);
    enter(16'h1111); idle(2);
    chk("s3 wrng1", 32'(wrng_atmpt), 1);
    chk("s3 cnt0", 32'(digit_cnt), 0);
    enter(16'h2222); idle(2);
    chk("s3 wrng2", 32'(wrng_atmpt), 2);
    enter(16'h3A7C); idle(2);
    chk("s3 unlock", 32'(unlock), 1);
    idle(10);
    open_session(16'h3A7C);
    repeat (3) begin enter(16'h1111); idle(2); end
    chk("s4 locked", 32'(locked), 1);
    chk("s4 wrng3", 32'(wrng_atmpt), 3);
    repeat (29) drive(1, 16'h0, 0, 4'h0, 0, 0);
    chk("s4 still locked", 32'(state), 6);
    idle(1);
    chk("s4 idle", 32'(state), 0);
    chk("s4 wrng cleared", 32'(wrng_atmpt), 0);
    open_session(16'h3A7C);
    lat(4'h3); lat(4'hA);
    idle(197);
    lat(4'h7);
    chk("s5 pre-expiry", 32'(expired), 0);
    idle(1);
    chk("s5 expired", 32'(expired), 1);
    chk("s5 cnt frozen", 32'(digit_cnt), 2);
    idle(9);
    chk("s5 expired held", 32'(state), 5);
    idle(1);
    chk("s5 idle", 32'(state), 0);
    open_session(16'h3A7C);
    enter(16'h3A7C); idle(2);
    chk("s6 in unlock", 32'(state), 4);
    reset = 0;
    idle(1);
    chk("s6 reset state", 32'(state), 0);
    chk("s6 reset unlock", 32'(unlock), 0);
    drive(1, 16'h0, 0, 4'h0, 0, 0);
    @(posedge clk); #2 reset = 1;
    drive(1, 16'h0, 0, 4'h0, 0, 0);
    chk("s6 async deassert", 32'(state), 0);
    idle(1);
    chk("s6 start after reset", 32'(state), 1);
    drive(0, 16'h3A7C, 1, 4'h0, 0, 0);
    lat(4'h3); lat(4'hA); lat(4'h7);
    idle(1);
    chk("s6 cnt3", 32'(digit_cnt), 3);
    reset = 0;
    idle(1);
    chk("s6 enter reset", 32'(state), 0);
    chk("s6 enter reset cnt", 32'(digit_cnt), 0);
    reset = 1;
    repeat (8000) begin
      @(negedge clk);
      reset = $urandom_range(0, 399) != 0;
      start = $urandom_range(0, 3) == 0;
      otp_valid = $urandom_range(0, 2) == 0;
      otp_in = 16'($urandom);
      user_digit = 4'($urandom);
      user_latch = $urandom_range(0, 3) == 0;
      user_del = $urandom_range(0, 7) == 0;
      if (m_state == 1) mode = $urandom_range(0, 2);
      if (m_state == 2) begin
        if (mode == 2) begin
          user_latch = 0;
          user_del = $urandom_range(0, 15) == 0;
        end else begin
          user_latch = $urandom_range(0, 1) == 1;
          if (mode == 0) user_digit = m_otp[15-4*dq.size() -: 4];
        end
      end
    end
    idle(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
